// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory port, decode handshake and control inputs.
// The master modport is the sequencer side; the slave modport is the memory/pipeline side.
interface fetch_sequencer_if #(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 8
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_gnt;
   logic [INSTR_W-1:0] imem_data;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               flush;
   logic [PC_W-1:0]    flush_pc;
   logic               halt;
   logic               halted;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, halted,
      input  imem_gnt, imem_data, out_ready, flush, flush_pc, halt
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, halted,
      output imem_gnt, imem_data, out_ready, flush, flush_pc, halt
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, resolves relative jumps at fetch, single-entry output.
// Optional FETCH_STATS_EN adds saturating fetch and bubble counters.
module fetch_sequencer #(
   parameter int unsigned     PC_W     = 8,
   parameter int unsigned     INSTR_W  = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef FETCH_STATS_EN
   output logic [15:0]          stat_fetch_o,
   output logic [15:0]          stat_bubble_o,
`endif
   fetch_sequencer_if.master    bus
);

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   state_e             state_q;
   logic [PC_W-1:0]    pc_q;
   logic               out_valid_q;
   logic [INSTR_W-1:0] out_instr_q;
   logic [PC_W-1:0]    out_pc_q;

   logic               slot_free;
   logic               req;
   logic               fire;
   logic               transfer;
   logic               is_jump;
   logic signed [5:0]  jump_off;
   logic [PC_W-1:0]    pc_next;

   always_comb begin
      slot_free = !out_valid_q || bus.out_ready;
      req       = (state_q == StRun) && slot_free;
      fire      = req && bus.imem_gnt;
      transfer  = out_valid_q && bus.out_ready;
      is_jump   = (bus.imem_data[7:6] == 2'b11);
      jump_off  = bus.imem_data[5:0];
      // Signed size cast sign-extends the offset; the sum wraps modulo 2**PC_W.
      pc_next   = is_jump ? pc_q + PC_W'(1) + PC_W'(jump_off) : pc_q + PC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StBoot;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         case (state_q)
            StBoot:  state_q <= (bus.halt && !bus.flush) ? StHalt : StRun;
            StRun:   state_q <= (bus.halt && !bus.flush) ? StHalt : StRun;
            StHalt:  state_q <= (!bus.halt && !bus.flush) ? StRun : StHalt;
            default: state_q <= StBoot;
         endcase

         if (bus.flush) begin
            pc_q        <= bus.flush_pc;
            out_valid_q <= 1'b0;
         end else if (fire) begin
            pc_q        <= pc_next;
            out_instr_q <= bus.imem_data;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
         end else if (transfer) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = pc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.halted    = (state_q == StHalt);

`ifdef FETCH_STATS_EN
   logic [15:0] stat_fetch_q;
   logic [15:0] stat_bubble_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_fetch_q  <= '0;
         stat_bubble_q <= '0;
      end else begin
         if (fire && !bus.flush && stat_fetch_q != 16'hFFFF) begin
            stat_fetch_q <= stat_fetch_q + 16'd1;
         end
         if (req && !bus.imem_gnt && stat_bubble_q != 16'hFFFF) begin
            stat_bubble_q <= stat_bubble_q + 16'd1;
         end
      end
   end

   assign stat_fetch_o  = stat_fetch_q;
   assign stat_bubble_o = stat_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer with hand sequences for jumps, halt-flush and reset.
module tb_fetch_sequencer;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [7:0] mem [256];

   fetch_sequencer_if #(.PC_W(8), .INSTR_W(8)) bus ();

`ifdef FETCH_STATS_EN
   logic [15:0] stat_fetch;
   logic [15:0] stat_bubble;
   fetch_sequencer #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst           (rst),
      .stat_fetch_o  (stat_fetch),
      .stat_bubble_o (stat_bubble),
      .bus           (bus.master)
   );
`else
   fetch_sequencer #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );
`endif

   assign bus.imem_data = mem[bus.imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       gnt;
      logic       ready;
      logic       flush;
      logic [7:0] fpc;
      logic       halt;
      logic       exp_req;
      logic [7:0] exp_addr;
      logic       exp_valid;
      logic       chk_pc;
      logic [7:0] exp_pc;
      logic       exp_halted;
   } vec_t;

   vec_t vecs [23];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      //             gnt  rdy  fl   fpc    halt req  addr   vld  chk  pc     hlt
      vecs[0]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
      vecs[1]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h00,1'b0,1'b0,8'h00,1'b0};
      vecs[2]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h01,1'b1,1'b1,8'h00,1'b0};
      vecs[3]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h02,1'b1,1'b1,8'h01,1'b0};
      vecs[4]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h03,1'b1,1'b1,8'h02,1'b0};
      vecs[5]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,8'h04,1'b1,1'b1,8'h03,1'b0};
      vecs[6]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,8'h04,1'b1,1'b1,8'h03,1'b0};
      vecs[7]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,8'h04,1'b1,1'b1,8'h03,1'b0};
      vecs[8]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h04,1'b1,1'b1,8'h03,1'b0};
      vecs[9]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,8'h05,1'b1,1'b1,8'h04,1'b0};
      vecs[10] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,8'h05,1'b0,1'b0,8'h00,1'b0};
      vecs[11] = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h05,1'b0,1'b0,8'h00,1'b0};
      vecs[12] = '{1'b1,1'b1,1'b1,8'h40,1'b0,1'b1,8'h06,1'b1,1'b1,8'h05,1'b0};
      vecs[13] = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h40,1'b0,1'b0,8'h00,1'b0};
      vecs[14] = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b1,8'h41,1'b1,1'b1,8'h40,1'b0};
      vecs[15] = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,8'h42,1'b1,1'b1,8'h41,1'b1};
      vecs[16] = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,8'h42,1'b0,1'b0,8'h00,1'b1};
      vecs[17] = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,8'h42,1'b0,1'b0,8'h00,1'b1};
      vecs[18] = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h42,1'b0,1'b0,8'h00,1'b1};
      vecs[19] = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h42,1'b0,1'b0,8'h00,1'b0};
      vecs[20] = '{1'b1,1'b1,1'b1,8'hFF,1'b0,1'b1,8'h43,1'b1,1'b1,8'h42,1'b0};
      vecs[21] = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'hFF,1'b0,1'b0,8'h00,1'b0};
      vecs[22] = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h00,1'b1,1'b1,8'hFF,1'b0};

      rst = 1'b1;
      bus.imem_gnt  = 1'b1;
      bus.out_ready = 1'b1;
      bus.flush     = 1'b0;
      bus.flush_pc  = 8'h00;
      bus.halt      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req",    32'(bus.imem_req),  32'h0);
      check("reset_valid",  32'(bus.out_valid), 32'h0);
      check("reset_pc",     32'(bus.out_pc),    32'h0);
      check("reset_instr",  32'(bus.out_instr), 32'h0);
      check("reset_halted", 32'(bus.halted),    32'h0);
      check("reset_addr",   32'(bus.imem_addr), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         bus.imem_gnt  = vecs[i].gnt;
         bus.out_ready = vecs[i].ready;
         bus.flush     = vecs[i].flush;
         bus.flush_pc  = vecs[i].fpc;
         bus.halt      = vecs[i].halt;
         #1;
         check($sformatf("v%0d_req", i),    32'(bus.imem_req),  32'(vecs[i].exp_req));
         check($sformatf("v%0d_addr", i),   32'(bus.imem_addr), 32'(vecs[i].exp_addr));
         check($sformatf("v%0d_valid", i),  32'(bus.out_valid), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_halted", i), 32'(bus.halted),    32'(vecs[i].exp_halted));
         if (vecs[i].chk_pc) begin
            check($sformatf("v%0d_out_pc", i), 32'(bus.out_pc), 32'(vecs[i].exp_pc));
         end
         step();
      end
`ifdef FETCH_STATS_EN
      check("stat_fetch",  32'(stat_fetch),  32'd11);
      check("stat_bubble", 32'(stat_bubble), 32'd2);
`endif

      // Jump +3 from 0x10
      mem[8'h10] = 8'hC3;
      bus.flush = 1'b1;
      bus.flush_pc = 8'h10;
      step();
      bus.flush = 1'b0;
      #1;
      check("jp_addr0", 32'(bus.imem_addr), 32'h10);
      step();
      check("jp_addr1",  32'(bus.imem_addr), 32'h14);
      check("jp_out_pc", 32'(bus.out_pc),    32'h10);
      check("jp_instr",  32'(bus.out_instr), 32'hC3);

      // Jump -2 from 0x10
      mem[8'h10] = 8'hFE;
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      step();
      check("jm_addr",  32'(bus.imem_addr), 32'h0F);
      check("jm_instr", 32'(bus.out_instr), 32'hFE);
      check("jm_valid", 32'(bus.out_valid), 32'h1);

      // Flush while halted moves pc only
      bus.halt = 1'b1;
      step();
      bus.flush = 1'b1;
      bus.flush_pc = 8'h20;
      #1;
      check("hf_halted0", 32'(bus.halted), 32'h1);
      step();
      bus.flush = 1'b0;
      #1;
      check("hf_addr",    32'(bus.imem_addr), 32'h20);
      check("hf_halted1", 32'(bus.halted),    32'h1);
      check("hf_req",     32'(bus.imem_req),  32'h0);
      bus.halt = 1'b0;
      step();
      check("hf_resume_halted", 32'(bus.halted),    32'h0);
      check("hf_resume_req",    32'(bus.imem_req),  32'h1);
      check("hf_resume_addr",   32'(bus.imem_addr), 32'h20);
      step();
      check("hf_out_pc", 32'(bus.out_pc),    32'h20);
      check("hf_addr2",  32'(bus.imem_addr), 32'h21);

      // Asynchronous reset mid-cycle
      #2;
      rst = 1'b1;
      #1;
      check("ar_valid",  32'(bus.out_valid), 32'h0);
      check("ar_req",    32'(bus.imem_req),  32'h0);
      check("ar_addr",   32'(bus.imem_addr), 32'h0);
      check("ar_out_pc", 32'(bus.out_pc),    32'h0);
`ifdef FETCH_STATS_EN
      check("ar_stat_fetch", 32'(stat_fetch), 32'h0);
`endif
      step();
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
